// File: rtl/wb_queue_pkg.sv
// Shared types for the writeback queue: register-file word, register address
// and the queued {addr, data} entry.
package wb_queue_pkg;

    typedef logic [63:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        creg_addr_t addr;
        word_t      data;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Youngest-match search over the occupied queue entries, used for decode bypass.
// Only built when WBQ_BYPASS_EN is defined.
`ifdef WBQ_BYPASS_EN
module wbq_lookup
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wbq_entry_t                   entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [$clog2(DEPTH):0]       count,
    input  creg_addr_t                   addr,
    output logic                         hit,
    output word_t                        data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr != '0) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule
`endif

// File: rtl/wb_queue.sv
// In-order writeback queue feeding the register file write port from two result
// sources. Optional decode bypass lookup is enabled by defining WBQ_BYPASS_EN.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    output logic       a_ready,
    input  creg_addr_t a_addr,
    input  word_t      a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  creg_addr_t b_addr,
    input  word_t      b_data,
    output logic       wvalid,
    output creg_addr_t wa,
    output word_t      wd,
    input  creg_addr_t lk_addr1,
    input  creg_addr_t lk_addr2,
    output logic       lk_hit1,
    output logic       lk_hit2,
    output word_t      lk_data1,
    output word_t      lk_data2
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wbq_entry_t     mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  b_slot;
    logic [CW-1:0]  count;
    logic           n_a;
    logic           a_store;
    logic           b_store;
    logic           deq;

    // Readiness looks only at the registered count; same-cycle drain earns no credit.
    assign n_a     = a_valid && (a_addr != '0);
    assign a_ready = count < CW'(DEPTH);
    assign b_ready = ({1'b0, count} + (CW + 1)'(n_a)) < (CW + 1)'(DEPTH);

    // x0 results complete the handshake but never occupy a slot.
    assign a_store = a_valid && a_ready && (a_addr != '0);
    assign b_store = b_valid && b_ready && (b_addr != '0);
    assign b_slot  = tail + PW'(a_store);
    assign deq     = (count != '0);

    assign wvalid = deq;
    assign wa     = mem[head].addr;
    assign wd     = mem[head].data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= '0;
            end
        end else begin
            if (a_store) begin
                mem[tail] <= '{addr: a_addr, data: a_data};
            end
            if (b_store) begin
                mem[b_slot] <= '{addr: b_addr, data: b_data};
            end
            head  <= head + PW'(deq);
            tail  <= tail + PW'(a_store) + PW'(b_store);
            count <= count + CW'(a_store) + CW'(b_store) - CW'(deq);
        end
    end

`ifdef WBQ_BYPASS_EN
    wbq_lookup #(.DEPTH(DEPTH)) u_lookup1 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .addr    (lk_addr1),
        .hit     (lk_hit1),
        .data    (lk_data1)
    );

    wbq_lookup #(.DEPTH(DEPTH)) u_lookup2 (
        .entries (mem),
        .head    (head),
        .count   (count),
        .addr    (lk_addr2),
        .hit     (lk_hit2),
        .data    (lk_data2)
    );
`else
    logic unused_lk;

    assign unused_lk = ^{lk_addr1, lk_addr2};
    assign lk_hit1   = 1'b0;
    assign lk_hit2   = 1'b0;
    assign lk_data1  = '0;
    assign lk_data2  = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a queue-based scoreboard predicts readiness,
// register-file writes and bypass lookups cycle by cycle.
module tb_wb_queue;
    import wb_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    creg_addr_t a_addr = '0;
    word_t      a_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    creg_addr_t b_addr = '0;
    word_t      b_data = '0;
    logic       wvalid;
    creg_addr_t wa;
    word_t      wd;
    creg_addr_t lk_addr1 = '0;
    creg_addr_t lk_addr2 = '0;
    logic       lk_hit1;
    logic       lk_hit2;
    word_t      lk_data1;
    word_t      lk_data2;

    int checks = 0;
    int errors = 0;
    wbq_entry_t sb[$];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .wvalid   (wvalid),
        .wa       (wa),
        .wd       (wd),
        .lk_addr1 (lk_addr1),
        .lk_addr2 (lk_addr2),
        .lk_hit1  (lk_hit1),
        .lk_hit2  (lk_hit2),
        .lk_data1 (lk_data1),
        .lk_data2 (lk_data2)
    );

    always #5 clk = ~clk;

    // Bypass reference: youngest pending entry in the scoreboard for this address.
    function automatic void model_lookup(input creg_addr_t addr, output logic hit, output word_t data);
        hit  = 1'b0;
        data = '0;
`ifdef WBQ_BYPASS_EN
        foreach (sb[i]) begin
            if (addr != 5'd0 && sb[i].addr == addr) begin
                hit  = 1'b1;
                data = sb[i].data;
            end
        end
`endif
    endfunction

    // One clock cycle: drive inputs after the falling edge, check outputs 1ns later,
    // then advance the scoreboard as the DUT will at the next rising edge.
    task automatic step(input logic av, input creg_addr_t aa, input word_t ad,
                        input logic bv, input creg_addr_t ba, input word_t bd,
                        output logic af, output logic bf);
        logic       ea, eb, ew, h1, h2;
        word_t      d1, d2;
        wbq_entry_t e;
        int         na;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        na = (av && aa != 5'd0) ? 1 : 0;
        ea = (sb.size() < DEPTH);
        eb = ((sb.size() + na) < DEPTH);
        ew = (sb.size() != 0);
        checks++;
        if (a_ready !== ea) begin
            errors++;
            $display("FAIL a_ready: got %b expected %b (t=%0t)", a_ready, ea, $time);
        end
        checks++;
        if (b_ready !== eb) begin
            errors++;
            $display("FAIL b_ready: got %b expected %b (t=%0t)", b_ready, eb, $time);
        end
        checks++;
        if (wvalid !== ew) begin
            errors++;
            $display("FAIL wvalid: got %b expected %b (t=%0t)", wvalid, ew, $time);
        end
        if (ew) begin
            e = sb[0];
            checks++;
            if (wa !== e.addr) begin
                errors++;
                $display("FAIL wa: got %0d expected %0d (t=%0t)", wa, e.addr, $time);
            end
            checks++;
            if (wd !== e.data) begin
                errors++;
                $display("FAIL wd: got %h expected %h (t=%0t)", wd, e.data, $time);
            end
        end
        model_lookup(lk_addr1, h1, d1);
        model_lookup(lk_addr2, h2, d2);
        checks++;
        if (lk_hit1 !== h1 || lk_data1 !== d1) begin
            errors++;
            $display("FAIL lookup1: got hit=%b data=%h expected hit=%b data=%h", lk_hit1, lk_data1, h1, d1);
        end
        checks++;
        if (lk_hit2 !== h2 || lk_data2 !== d2) begin
            errors++;
            $display("FAIL lookup2: got hit=%b data=%h expected hit=%b data=%h", lk_hit2, lk_data2, h2, d2);
        end
        if (ew) void'(sb.pop_front());
        af = av && ea;
        bf = bv && eb;
        if (af && aa != 5'd0) sb.push_back('{addr: aa, data: ad});
        if (bf && ba != 5'd0) sb.push_back('{addr: ba, data: bd});
    endtask

    task automatic idle(input int unsigned n);
        logic af, bf;
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, af, bf);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (wvalid !== 1'b0 || wa !== 5'd0 || wd !== 64'd0) begin
            errors++;
            $display("FAIL %s write port: got wvalid=%b wa=%0d wd=%h expected 0/0/0", tag, wvalid, wa, wd);
        end
        checks++;
        if (lk_hit1 !== 1'b0 || lk_hit2 !== 1'b0 || lk_data1 !== 64'd0 || lk_data2 !== 64'd0) begin
            errors++;
            $display("FAIL %s lookup: got hit=%b%b data1=%h data2=%h expected zeros", tag, lk_hit1, lk_hit2, lk_data1, lk_data2);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        lk_addr1 = 5'd7;
        #1;
        check_reset_outputs("reset");
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset ready: got a=%b b=%b expected 1/1", a_ready, b_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        lk_addr1 = '0;
    endtask

    task automatic test_single();
        logic af, bf;
        lk_addr1 = 5'd5;
        step(1'b1, 5'd5, 64'h1234, 1'b0, '0, '0, af, bf);
        idle(3);
        lk_addr1 = '0;
    endtask

    task automatic test_same_cycle();
        logic af, bf;
        lk_addr1 = 5'd3;
        step(1'b1, 5'd3, 64'd1, 1'b1, 5'd3, 64'd2, af, bf);
        idle(4);
        lk_addr1 = '0;
    endtask

    task automatic test_back_to_back();
        logic af, bf;
        creg_addr_t bh_addr;
        word_t      bh_data;
        bh_addr = 5'd20;
        bh_data = {32'hb0b0_0000, $urandom};
        lk_addr1 = 5'd12;
        lk_addr2 = 5'd20;
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, 5'(10 + i), {32'ha0a0_0000, $urandom}, 1'b1, bh_addr, bh_data, af, bf);
            // B holds its result until accepted, as a real producer would.
            if (bf) begin
                bh_addr = bh_addr + 5'd1;
                bh_data = {32'hb0b0_0000, $urandom};
            end
        end
        idle(6);
        lk_addr1 = '0;
        lk_addr2 = '0;
    endtask

    task automatic test_x0_filter();
        logic af, bf;
        step(1'b1, 5'd0, 64'hdead, 1'b0, '0, '0, af, bf);
        step(1'b0, '0, '0, 1'b1, 5'd0, 64'hbeef, af, bf);
        idle(3);
    endtask

    task automatic test_bypass();
        logic af, bf;
        lk_addr1 = 5'd7;
        lk_addr2 = 5'd0;
        step(1'b1, 5'd1, 64'h11, 1'b1, 5'd7, 64'hA, af, bf);
        step(1'b1, 5'd9, 64'hB, 1'b1, 5'd7, 64'hC, af, bf);
        idle(1);
`ifdef WBQ_BYPASS_EN
        checks++;
        if (lk_hit1 !== 1'b1 || lk_data1 !== 64'hC || lk_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL bypass youngest: got hit1=%b data1=%h hit2=%b expected 1/c/0", lk_hit1, lk_data1, lk_hit2);
        end
`endif
        idle(4);
        lk_addr1 = '0;
    endtask

    task automatic test_async_reset();
        logic af, bf;
        step(1'b1, 5'd1, 64'h21, 1'b1, 5'd2, 64'h22, af, bf);
        step(1'b1, 5'd4, 64'h24, 1'b1, 5'd6, 64'h26, af, bf);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async reset");
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_back_to_back();
        test_x0_filter();
        test_bypass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
